// File: rtl/sprite_scheduler.sv
// Sprite scheduler: per-sprite start pulses, hblank ROM load arbitration and pixel merge.
// state | meaning: IDLE wait for hblank | SCAN test sel | LOAD grant | SETUP addr latch | FETCH data latch
module sprite_scheduler #(
    parameter int NUM_SPR    = 4,
    parameter int POS_W      = 9,
    parameter int IMG_W      = 2,
    parameter int LOAD_START = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [POS_W-1:0]           hpos,
    input  logic [POS_W-1:0]           vpos,
    input  logic [NUM_SPR*POS_W-1:0]   spr_x,
    input  logic [NUM_SPR*POS_W-1:0]   spr_y,
    input  logic [NUM_SPR*IMG_W-1:0]   spr_img,
    input  logic [NUM_SPR*4-1:0]       spr_rom_addr,
    input  logic [NUM_SPR-1:0]         spr_in_progress,
    input  logic [NUM_SPR-1:0]         spr_gfx,
    output logic [NUM_SPR-1:0]         vstart,
    output logic [NUM_SPR-1:0]         hstart,
    output logic [NUM_SPR-1:0]         load,
    output logic [IMG_W+3:0]           rom_addr,
    output logic                       rom_busy,
    output logic                       gfx,
    output logic [2:0]                 gfx_id,
    output logic                       collision
);
    localparam int SEL_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam logic [POS_W-1:0] LS   = POS_W'(LOAD_START);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SPR - 1);

    typedef enum logic [2:0] {IDLE, SCAN, LOAD, SETUP, FETCH} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel, sel_nxt;

    logic [POS_W-1:0] x_arr    [NUM_SPR];
    logic [POS_W-1:0] y_arr    [NUM_SPR];
    logic [IMG_W-1:0] img_arr  [NUM_SPR];
    logic [3:0]       addr_arr [NUM_SPR];

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_unpack
        assign x_arr[g]    = spr_x[g*POS_W +: POS_W];
        assign y_arr[g]    = spr_y[g*POS_W +: POS_W];
        assign img_arr[g]  = spr_img[g*IMG_W +: IMG_W];
        assign addr_arr[g] = spr_rom_addr[g*4 +: 4];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                sel_nxt = '0;
                if (hpos == LS) state_nxt = SCAN;
            end
            SCAN: begin
                if (spr_in_progress[sel]) begin
                    state_nxt = LOAD;
                end else if (sel == LAST) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                end else begin
                    sel_nxt = sel + SEL_W'(1);
                end
            end
            LOAD:  state_nxt = SETUP;
            SETUP: state_nxt = FETCH;
            FETCH: begin
                if (sel == LAST) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                end else begin
                    state_nxt = SCAN;
                    sel_nxt   = sel + SEL_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
        endcase
    end

    // Grant decoded purely from registered state/sel, so it cannot glitch.
    always_comb begin
        load = '0;
        if (state == LOAD) load[sel] = 1'b1;
    end

    assign rom_busy = (state != IDLE);
    assign rom_addr = {img_arr[sel], addr_arr[sel]};

    logic [NUM_SPR-1:0] vs_nxt, hs_nxt;
    logic [2:0]         first_id;
    logic               multi;

    always_comb begin
        vs_nxt = '0;
        hs_nxt = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            vs_nxt[i] = (hpos == '0) && (vpos == y_arr[i]);
            hs_nxt[i] = (hpos == x_arr[i]) && (x_arr[i] < LS);
        end
    end

    always_comb begin
        first_id = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (spr_gfx[i]) first_id = 3'(i);
        end
    end

    assign multi = (spr_gfx & (spr_gfx - NUM_SPR'(1))) != '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vstart    <= '0;
            hstart    <= '0;
            gfx       <= 1'b0;
            gfx_id    <= '0;
            collision <= 1'b0;
        end else begin
            vstart <= vs_nxt;
            hstart <= hs_nxt;
            gfx    <= |spr_gfx;
            gfx_id <= first_id;
            // A new overlap in the frame-start cycle takes priority over the clear.
            if (multi)
                collision <= 1'b1;
            else if (hpos == '0 && vpos == '0)
                collision <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: directed scenarios then randomized traffic
// compared against a schedule-queue reference model.
module tb_sprite_scheduler;
    localparam int HTOT = 320;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  hpos, vpos;
    logic [35:0] spr_x, spr_y;
    logic [7:0]  spr_img;
    logic [15:0] spr_rom_addr;
    logic [3:0]  spr_in_progress, spr_gfx;
    logic [3:0]  vstart, hstart, load;
    logic [5:0]  rom_addr;
    logic        rom_busy, gfx, collision;
    logic [2:0]  gfx_id;

    int checks = 0;
    int errors = 0;
    int vtot   = 64;

    sprite_scheduler dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .spr_x(spr_x), .spr_y(spr_y), .spr_img(spr_img), .spr_rom_addr(spr_rom_addr),
        .spr_in_progress(spr_in_progress), .spr_gfx(spr_gfx),
        .vstart(vstart), .hstart(hstart), .load(load), .rom_addr(rom_addr),
        .rom_busy(rom_busy), .gfx(gfx), .gfx_id(gfx_id), .collision(collision)
    );

    always #5 clk = ~clk;

    // Reference: a round is a list of per-cycle slots, 1 per idle sprite, 4 per active one.
    typedef struct {
        logic [3:0] ld;
        bit         fetch;
        int         spr;
    } ent_t;

    ent_t       q[$];
    ent_t       cur;
    bit         cur_v;
    logic [3:0] e_vs, e_hs;
    logic       e_gfx, e_coll;
    logic [2:0] e_id;

    function automatic logic [8:0] gx(int i); return spr_x[i*9 +: 9]; endfunction
    function automatic logic [8:0] gy(int i); return spr_y[i*9 +: 9]; endfunction
    function automatic logic [5:0] exp_addr(int i);
        return {spr_img[i*2 +: 2], spr_rom_addr[i*4 +: 4]};
    endfunction

    function automatic logic [2:0] lowest(logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic model_reset();
        cur_v = 0;
        q.delete();
        e_vs = '0; e_hs = '0; e_gfx = 0; e_id = '0; e_coll = 0;
    endtask

    task automatic model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            e_vs[i] = (hpos == 0) && (vpos == gy(i));
            e_hs[i] = (hpos == gx(i)) && (gx(i) < 9'd256);
        end
        e_gfx = (spr_gfx != 0);
        e_id  = lowest(spr_gfx);
        if ($countones(spr_gfx) >= 2) e_coll = 1;
        else if (hpos == 0 && vpos == 0) e_coll = 0;
        if (cur_v) begin
            if (q.size() > 0) cur = q.pop_front();
            else cur_v = 0;
        end else if (hpos == 9'd256) begin
            q.delete();
            for (int i = 0; i < 4; i++) begin
                q.push_back('{ld: 4'b0, fetch: 1'b0, spr: i});
                if (spr_in_progress[i]) begin
                    q.push_back('{ld: 4'(1 << i), fetch: 1'b0, spr: i});
                    q.push_back('{ld: 4'b0, fetch: 1'b0, spr: i});
                    q.push_back('{ld: 4'b0, fetch: 1'b1, spr: i});
                end
            end
            cur   = q.pop_front();
            cur_v = 1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (hpos %0d vpos %0d)", tag, got, exp, hpos, vpos);
        end
    endtask

    task automatic check_all();
        chk("vstart",    32'(vstart),    32'(e_vs));
        chk("hstart",    32'(hstart),    32'(e_hs));
        chk("gfx",       32'(gfx),       32'(e_gfx));
        chk("gfx_id",    32'(gfx_id),    32'(e_id));
        chk("collision", 32'(collision), 32'(e_coll));
        chk("rom_busy",  32'(rom_busy),  32'(cur_v));
        chk("load",      32'(load),      cur_v ? 32'(cur.ld) : 32'd0);
        if (cur_v && cur.fetch) chk("rom_addr_fetch", 32'(rom_addr), 32'(exp_addr(cur.spr)));
        if (!reset) chk("rom_addr_reset", 32'(rom_addr), 32'(exp_addr(0)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic advance();
        if (hpos == 9'(HTOT - 1)) begin
            hpos = '0;
            vpos = (vpos == 9'(vtot - 1)) ? 9'd0 : vpos + 9'd1;
        end else begin
            hpos = hpos + 9'd1;
        end
    endtask

    task automatic randomize_inputs();
        if (hpos == 0) begin
            for (int i = 0; i < 4; i++) begin
                spr_x[i*9 +: 9] = 9'($urandom_range(0, HTOT - 1));
                spr_y[i*9 +: 9] = 9'($urandom_range(0, vtot - 1));
            end
            spr_img = 8'($urandom);
        end
        spr_rom_addr = 16'($urandom);
        for (int i = 0; i < 4; i++) spr_gfx[i] = ($urandom_range(0, 5) == 0);
        if (!cur_v && $urandom_range(0, 49) == 0) spr_in_progress = 4'($urandom);
    endtask

    task automatic run(int n, bit rnd);
        for (int k = 0; k < n; k++) begin
            if (rnd) randomize_inputs();
            tick();
            advance();
        end
    endtask

    initial begin
        model_reset();
        reset           = 1'b0;
        hpos            = 9'd256;
        vpos            = 9'd0;
        spr_x           = {9'd200, 9'd150, 9'd100, 9'd50};
        spr_y           = {9'd30, 9'd20, 9'd40, 9'd10};
        spr_img         = {2'd1, 2'd3, 2'd2, 2'd0};
        spr_rom_addr    = {4'h9, 4'h5, 4'h7, 4'h3};
        spr_in_progress = 4'b1111;
        spr_gfx         = 4'b0000;

        // Reset held with hpos at the load point: no grants may appear.
        repeat (3) tick();
        reset = 1'b1;
        hpos  = 9'd257;
        // Full round with all renderers active; sprite 2 fetch address is {3,5} = 0x35.
        run(HTOT + 20, 0);

        spr_in_progress = 4'b0100;
        run(HTOT, 0);

        // Sprite 1 at y=40, x=100, then moved out of the hstart-eligible range.
        hpos = 9'd0; vpos = 9'd40;
        run(HTOT, 0);
        spr_x[9 +: 9] = 9'd300;
        run(HTOT, 0);

        // Overlap just before frame start: collision held, then cleared at hpos=0/vpos=0.
        hpos = 9'd300; vpos = 9'd63;
        spr_gfx = 4'b0110;
        tick();
        advance();
        spr_gfx = 4'b0000;
        run(30, 0);

        // Reset in the middle of a round (SETUP of sprite 1).
        spr_in_progress = 4'b1111;
        hpos = 9'd250; vpos = 9'd5;
        run(13, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        hpos = 9'd256;
        repeat (3) tick();
        reset = 1'b1;
        hpos  = 9'd257;
        run(HTOT + 30, 0);

        // Randomized traffic with short frames so frame-start clears happen often.
        vtot = 4;
        hpos = 9'd0; vpos = 9'd0;
        run(20000, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
